// File: rtl/ccg_resp_misr.sv
// ccg_resp_misr
// Multiple-input signature register (MISR). It compacts a fixed number of
// response vectors from a combinational circuit under test into one
// signature, then compares that signature against a golden value.
//
// Parameters
//   F_WIDTH    width of the response vector (f1..f19 -> bits 0..18)
//   POLY       feedback taps (default x^19 + x^6 + x^2 + x + 1)
//   SEED       signature value loaded at the start of every run
//   N_PATTERNS number of responses compacted per run (1..65535)
//   GOLDEN     expected final signature
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous, active-low reset
//   start    begins a run when sampled high in IDLE or DONE
//   f        response vector; bit i is output f(i+1) of the circuit under test
//   f_valid  f holds a response to be compacted
//   f_ready  high only in RUN; a response is accepted when f_valid is also high
//   sig      current signature register
//   count    number of responses accepted in the current run
//   done     run complete, sig is final (held until the next start or reset)
//   pass     done and sig == GOLDEN
module ccg_resp_misr #(
    parameter int                 F_WIDTH    = 19,
    parameter logic [F_WIDTH-1:0] POLY       = 19'h00047,
    parameter logic [F_WIDTH-1:0] SEED       = 19'h00000,
    parameter int                 N_PATTERNS = 16,
    parameter logic [F_WIDTH-1:0] GOLDEN     = 19'h00000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [F_WIDTH-1:0] f,
    input  logic               f_valid,
    output logic               f_ready,
    output logic [F_WIDTH-1:0] sig,
    output logic [15:0]        count,
    output logic               done,
    output logic               pass
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [15:0] LAST_COUNT = 16'(N_PATTERNS);

    state_t             state;
    logic               accept;
    logic               msb;
    logic [F_WIDTH-1:0] sig_next;
    logic [15:0]        count_next;

    assign f_ready    = (state == RUN);
    assign accept     = f_ready & f_valid;
    assign msb        = sig[F_WIDTH-1];
    assign count_next = count + 16'd1;

    // Rotate left so the old MSB lands in bit 0, fold in the response, then
    // apply the feedback taps to bits 1 and up. POLY[0] stands for the x^0
    // term, which the rotation already provides, so that bit is masked off.
    assign sig_next = {sig[F_WIDTH-2:0], msb}
                    ^ f
                    ^ ({POLY[F_WIDTH-1:1], 1'b0} & {F_WIDTH{msb}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sig   <= SEED;
            count <= '0;
            done  <= 1'b0;
        end else begin
            case (state)
                // A start here takes priority over any f_valid in the same
                // cycle: f_ready is still low, so nothing is accepted.
                IDLE, DONE: begin
                    if (start) begin
                        state <= RUN;
                        sig   <= SEED;
                        count <= '0;
                        done  <= 1'b0;
                    end
                end
                // start is ignored while a run is in progress.
                RUN: begin
                    if (accept) begin
                        sig   <= sig_next;
                        count <= count_next;
                        if (count_next == LAST_COUNT) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign pass = done & (sig == GOLDEN);

endmodule
